// File: rtl/sender_pkg.sv
// Shared types, constants and the CRC-8 helper for the sender framing path.
package sender_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StHeader,
        StPayload,
        StCrc
    } state_e;

    localparam logic [7:0] CRC8_POLY             = 8'h07;
    localparam logic [7:0] DEFAULT_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] DEFAULT_SFD_BYTE      = 8'hD5;

    // MSB-first, non-reflected, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with asynchronous active-high reset; a push into a full FIFO
// succeeds when a pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define the contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sender_frame_scheduler.sv
// Samples the ADC at a divided rate into a FIFO and emits framed bytes
// (preamble, SFD, sequence header, payload, CRC-8) over a valid/ready stream.
module sender_frame_scheduler
    import sender_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = 360,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PREAMBLE_LEN  = 8,
    parameter int unsigned PAYLOAD_LEN   = 16,
    parameter logic [7:0]  PREAMBLE_BYTE = DEFAULT_PREAMBLE_BYTE,
    parameter logic [7:0]  SFD_BYTE      = DEFAULT_SFD_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sender_sync_in,
    input  logic [7:0] sender_ad,
    output logic [7:0] sym_data,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_last,
    output logic       sender_sync_out,
    output logic       overrun,
    output logic [7:0] frame_seq
);

    localparam int unsigned MAX_LEN = (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       seq_q, seq_d;
    logic             overrun_q, overrun_d;

    logic       tick;
    logic       accept;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    sample_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tick),
        .pop   (fifo_pop),
        .din   (sender_ad),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick      = sender_sync_in & (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    assign accept    = sym_valid & sym_ready;
    assign overrun   = overrun_q;
    assign frame_seq = seq_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every move except the frame start waits for a handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sender_sync_in && !fifo_empty) state_d = StPreamble;
            end
            StPreamble: begin
                if (accept && byte_cnt_q == CNT_W'(PREAMBLE_LEN - 1)) state_d = StSfd;
            end
            StSfd: begin
                if (accept) state_d = StHeader;
            end
            StHeader: begin
                if (accept) state_d = StPayload;
            end
            StPayload: begin
                if (accept && byte_cnt_q == CNT_W'(PAYLOAD_LEN - 1)) state_d = StCrc;
            end
            StCrc: begin
                if (accept) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only; sym_ready merely gates the pop and sync pulse.
    always_comb begin
        sym_valid = 1'b0;
        sym_data  = '0;
        sym_last  = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StPreamble: begin
                sym_valid = 1'b1;
                sym_data  = PREAMBLE_BYTE;
            end
            StSfd: begin
                sym_valid = 1'b1;
                sym_data  = SFD_BYTE;
            end
            StHeader: begin
                sym_valid = 1'b1;
                sym_data  = seq_q;
            end
            StPayload: begin
                sym_valid = ~fifo_empty;
                sym_data  = fifo_dout;
                fifo_pop  = ~fifo_empty & sym_ready;
            end
            StCrc: begin
                sym_valid = 1'b1;
                sym_data  = crc_q;
                sym_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign sender_sync_out = (state_q == StSfd) & sym_ready;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (!sender_sync_in || tick) begin
            div_cnt_d = '0;
        end

        byte_cnt_d = byte_cnt_q;
        if (state_d != state_q) begin
            byte_cnt_d = '0;
        end else if (accept && (state_q == StPreamble || state_q == StPayload)) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end

        crc_d = crc_q;
        if (accept) begin
            if (state_q == StSfd) begin
                crc_d = 8'h00;
            end else if (state_q == StHeader || state_q == StPayload) begin
                crc_d = crc8_update(crc_q, sym_data);
            end
        end

        seq_d = (accept && state_q == StCrc) ? seq_q + 8'd1 : seq_q;

        // A tick into a full FIFO is only lost when no pop frees a slot that cycle.
        overrun_d = overrun_q | (tick & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= '0;
            byte_cnt_q <= '0;
            crc_q      <= '0;
            seq_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            seq_q      <= seq_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sender_frame_scheduler.sv
// Randomized bench for sender_frame_scheduler: samples are queued as they are
// taken, and a negedge monitor rebuilds each frame from them and compares.
module tb_sender_frame_scheduler;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int PRE   = 2;
    localparam int PAY   = 4;
    localparam int FLEN  = PRE + 3 + PAY;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sync_in = 1'b0;
    logic [7:0] ad = 8'h00;
    logic       sym_ready = 1'b0;
    logic [7:0] sym_data;
    logic       sym_valid;
    logic       sym_last;
    logic       sync_out;
    logic       overrun;
    logic [7:0] frame_seq;

    int checks = 0;
    int errors = 0;

    sender_frame_scheduler #(
        .SAMPLE_DIV    (DIV),
        .FIFO_DEPTH    (DEPTH),
        .PREAMBLE_LEN  (PRE),
        .PAYLOAD_LEN   (PAY),
        .PREAMBLE_BYTE (8'h55),
        .SFD_BYTE      (8'hD5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .sender_sync_in  (sync_in),
        .sender_ad       (ad),
        .sym_data        (sym_data),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_last        (sym_last),
        .sender_sync_out (sync_out),
        .overrun         (overrun),
        .frame_seq       (frame_seq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07) over a whole message.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ msg[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Reference model state.
    logic [7:0] samp_q[$];
    logic [7:0] frame_msg[$];
    bit         in_frame = 0;
    int         pos = 0;
    int         run_len = 0;
    logic [7:0] m_seq = 8'h00;
    bit         m_ovr = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    bit         ev, hs, tick, start, in_pay;
    logic [7:0] eb;

    always @(negedge clock) begin
        if (reset) begin
            samp_q.delete();
            frame_msg.delete();
            in_frame   = 0;
            pos        = 0;
            run_len    = 0;
            m_seq      = 8'h00;
            m_ovr      = 0;
            prev_stall = 0;
        end else begin
            in_pay = in_frame && pos >= PRE + 2 && pos < PRE + 2 + PAY;
            ev     = in_frame && !(in_pay && samp_q.size() == 0);
            chk("sym_valid", sym_valid, ev);
            chk("overrun", overrun, m_ovr);
            chk("frame_seq", frame_seq, m_seq);
            chk("sync_out", sync_out, ev && sym_ready && pos == PRE);
            if (prev_stall && sym_valid) chk("hold_data", sym_data, prev_data);
            eb = 8'h00;
            if (ev) begin
                if (pos < PRE)           eb = 8'h55;
                else if (pos == PRE)     eb = 8'hD5;
                else if (pos == PRE + 1) eb = m_seq;
                else if (in_pay)         eb = samp_q[0];
                else                     eb = ref_crc(frame_msg);
                chk("sym_data", sym_data, eb);
                chk("sym_last", sym_last, pos == FLEN - 1);
            end
            prev_stall = sym_valid && !sym_ready;
            prev_data  = sym_data;

            hs    = ev && sym_ready;
            tick  = sync_in && (run_len % DIV == DIV - 1);
            start = !in_frame && sync_in && samp_q.size() != 0;
            if (hs) begin
                if (pos == PRE + 1 || in_pay) frame_msg.push_back(eb);
                if (in_pay) void'(samp_q.pop_front());
                if (pos == FLEN - 1) begin
                    in_frame = 0;
                    pos      = 0;
                    m_seq    = m_seq + 8'd1;
                    frame_msg.delete();
                end else begin
                    pos++;
                end
            end
            if (start) begin
                in_frame = 1;
                pos      = 0;
            end
            if (tick) begin
                if (samp_q.size() < DEPTH) samp_q.push_back(ad);
                else m_ovr = 1;
            end
            run_len = sync_in ? run_len + 1 : 0;
        end
    end

    // Reset must clear the outputs without waiting for a clock edge.
    always @(posedge reset) begin
        #1;
        chk("rst_valid", sym_valid, 0);
        chk("rst_last", sym_last, 0);
        chk("rst_data", sym_data, 0);
        chk("rst_sync_out", sync_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_seq", frame_seq, 0);
    end

    task automatic run_cycles(input int n, input bit rand_ready);
        repeat (n) begin
            @(posedge clock);
            #1;
            ad = 8'($urandom);
            if (rand_ready) sym_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Leaves the caller at posedge+3 of a cycle whose model position matches.
    task automatic wait_pos(input string name, input int lo, input int hi);
        bit found;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clock);
            #3;
            if (in_frame && pos >= lo && pos <= hi) found = 1;
        end
        chk(name, found, 1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Free-running frames.
        sync_in   = 1'b1;
        sym_ready = 1'b1;
        run_cycles(200, 0);

        // Random backpressure.
        run_cycles(400, 1);

        // Overrun: hold off the consumer long enough to drop samples.
        do_reset();
        sym_ready = 1'b0;
        run_cycles(6 * DIV + 6, 0);
        run_cycles(200, 1);

        // sync_in drops in the middle of a payload.
        sym_ready = 1'b1;
        wait_pos("wait_payload", PRE + 3, PRE + 1 + PAY);
        sync_in = 1'b0;
        run_cycles(60, 0);
        sync_in = 1'b1;
        run_cycles(120, 1);

        // Asynchronous reset while the header is on the bus.
        sym_ready = 1'b0;
        wait_pos("wait_header", PRE + 1, PRE + 1);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        sym_ready = 1'b1;
        run_cycles(150, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
